// File: rtl/temp_sample_controller.sv
// Periodic temperature sampler: triggers an ADC conversion every SAMPLE_DIV
// clocks, runs the result through an external calculator and publishes a
// 2^AVG_LOG2-sample average over a valid/ready handshake.
module temp_sample_controller #(
  parameter int unsigned SAMPLE_DIV  = 16,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned CALC_LAT    = 1,
  parameter int unsigned ADC_TIMEOUT = 8,
  parameter logic [31:0] DEF_BASE    = 32'd1,
  parameter logic [7:0]  DEF_REF     = 8'd24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cfg_load,
  input  logic [31:0] cfg_base,
  input  logic [7:0]  cfg_ref,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [15:0] adc_data_in,
  output logic [31:0] tc_base,
  output logic [7:0]  tc_ref,
  output logic [15:0] tc_adc,
  input  logic [31:0] tc_tempc,
  output logic [31:0] temp_out,
  output logic        temp_valid,
  input  logic        temp_ready,
  output logic        err_timeout,
  output logic        overrun,
  input  logic        err_clr,
  output logic        busy
);

  localparam int unsigned TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TO_W   = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam int unsigned CALC_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned ACC_W  = 32 + AVG_LOG2;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(ADC_TIMEOUT - 1);
  localparam logic [CALC_W-1:0] CALC_LAST  = CALC_W'(CALC_LAT - 1);
  localparam logic [CNT_W-1:0]  COUNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_CONVERT,
    S_CALC,
    S_ACCUM,
    S_PUBLISH
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [CALC_W-1:0]   r_calc_cnt;
  logic [CNT_W-1:0]    r_count;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_acc_sum;
  logic [31:0]         r_shadow_base;
  logic [7:0]          r_shadow_ref;
  logic [31:0]         r_tc_base;
  logic [7:0]          r_tc_ref;
  logic [15:0]         r_tc_adc;
  logic [31:0]         r_temp_out;
  logic                r_temp_valid;
  logic                r_adc_start;
  logic                r_err_timeout;
  logic                r_overrun;
  logic                r_busy;
  logic                w_tick;
  logic                w_launch;
  logic                w_accept;
  logic                w_timeout;
  logic                w_accum;
  logic                w_avg_done;
  logic                w_abort;
  logic                w_overrun;

  assign w_tick    = enable && (r_state != S_IDLE) && (r_tick_cnt == TICK_LAST);
  assign w_overrun = w_tick && (r_state != S_WAIT_TICK);
  assign w_acc_sum = r_acc + ACC_W'(tc_tempc);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-cycle action decode
  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_accept   = 1'b0;
    w_timeout  = 1'b0;
    w_accum    = 1'b0;
    w_avg_done = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else if (w_tick) begin
          w_next   = S_START;
          w_launch = 1'b1;
        end
      end
      S_START: begin
        w_abort = !enable;
        w_next  = enable ? S_CONVERT : S_IDLE;
      end
      S_CONVERT: begin
        if (!enable) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else if (adc_done) begin
          w_next   = S_CALC;
          w_accept = 1'b1;
        end else if (r_to_cnt == TO_LAST) begin
          w_next    = S_WAIT_TICK;
          w_timeout = 1'b1;
        end
      end
      S_CALC: begin
        if (!enable) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else if (r_calc_cnt == CALC_LAST) begin
          w_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!enable) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_accum = 1'b1;
          if (r_count == COUNT_LAST) begin
            w_avg_done = 1'b1;
            w_next     = S_PUBLISH;
          end else begin
            w_next = S_WAIT_TICK;
          end
        end
      end
      S_PUBLISH: begin
        if (r_temp_valid && temp_ready) w_next = enable ? S_WAIT_TICK : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sample timebase and the per-conversion/settle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_to_cnt   <= '0;
      r_calc_cnt <= '0;
    end else begin
      if (r_state == S_IDLE)          r_tick_cnt <= '0;
      else if (enable)                r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0
                                                    : r_tick_cnt + TICK_W'(1);
      // Counts from the adc_start cycle so the timeout lands ADC_TIMEOUT clocks after it
      if (w_launch)                   r_to_cnt <= '0;
      else if (((r_state == S_START) || (r_state == S_CONVERT)) && (r_to_cnt != TO_LAST))
                                      r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_accept)                   r_calc_cnt <= '0;
      else if ((r_state == S_CALC) && (r_calc_cnt != CALC_LAST))
                                      r_calc_cnt <= r_calc_cnt + CALC_W'(1);
    end
  end

  // Configuration shadow and calculator operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_base <= DEF_BASE;
      r_shadow_ref  <= DEF_REF;
      r_tc_base     <= DEF_BASE;
      r_tc_ref      <= DEF_REF;
      r_tc_adc      <= '0;
    end else begin
      if (cfg_load) begin
        r_shadow_base <= cfg_base;
        r_shadow_ref  <= cfg_ref;
      end
      if (w_launch) begin
        r_tc_base <= r_shadow_base;
        r_tc_ref  <= r_shadow_ref;
      end
      if (w_accept) r_tc_adc <= adc_data_in;
    end
  end

  // Averaging datapath and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc         <= '0;
      r_count       <= '0;
      r_temp_out    <= '0;
      r_temp_valid  <= 1'b0;
      r_adc_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_adc_start  <= w_launch;
      r_busy       <= (w_next != S_IDLE);
      r_temp_valid <= (w_next == S_PUBLISH);
      if (w_abort) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_avg_done) begin
        r_temp_out <= 32'(w_acc_sum >> AVG_LOG2);
        r_acc      <= '0;
        r_count    <= '0;
      end else if (w_accum) begin
        r_acc   <= w_acc_sum;
        r_count <= r_count + CNT_W'(1);
      end
      // Set wins over a same-cycle clear
      if (w_timeout)    r_err_timeout <= 1'b1;
      else if (err_clr) r_err_timeout <= 1'b0;
      if (w_overrun)    r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
    end
  end

  assign adc_start   = r_adc_start;
  assign tc_base     = r_tc_base;
  assign tc_ref      = r_tc_ref;
  assign tc_adc      = r_tc_adc;
  assign temp_out    = r_temp_out;
  assign temp_valid  = r_temp_valid;
  assign err_timeout = r_err_timeout;
  assign overrun     = r_overrun;
  assign busy        = r_busy;

endmodule

// File: tb/tb_temp_sample_controller.sv
// Directed bench for temp_sample_controller: ADC/calculator stubs plus one
// task per scenario with hand-computed expectations.
module tb_temp_sample_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_load;
  logic [31:0] cfg_base;
  logic [7:0]  cfg_ref;
  logic        adc_start;
  logic        adc_done;
  logic [15:0] adc_data_in;
  logic [31:0] tc_base;
  logic [7:0]  tc_ref;
  logic [15:0] tc_adc;
  logic [31:0] tc_tempc;
  logic [31:0] temp_out;
  logic        temp_valid;
  logic        temp_ready;
  logic        err_timeout;
  logic        overrun;
  logic        err_clr;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_starts = 0;

  // Stub controls owned by the main sequence
  bit          adc_en = 1'b0;
  int          seed_gen = 0;
  int unsigned tempc_base = 100;

  temp_sample_controller dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_load    (cfg_load),
    .cfg_base    (cfg_base),
    .cfg_ref     (cfg_ref),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_data_in (adc_data_in),
    .tc_base     (tc_base),
    .tc_ref      (tc_ref),
    .tc_adc      (tc_adc),
    .tc_tempc    (tc_tempc),
    .temp_out    (temp_out),
    .temp_valid  (temp_valid),
    .temp_ready  (temp_ready),
    .err_timeout (err_timeout),
    .overrun     (overrun),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (adc_start === 1'b1) n_starts <= n_starts + 1;
  end

  // ADC answers 3 cycles after adc_start; calculator yields base, base+2, ...
  initial begin
    int pend;
    int idx;
    int my_gen;
    pend = 0; idx = 0; my_gen = 0;
    adc_done = 1'b0; adc_data_in = '0; tc_tempc = '0;
    forever begin
      @(posedge clk); #2;
      adc_done = 1'b0;
      if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          if (my_gen != seed_gen) begin
            my_gen = seed_gen;
            idx = 0;
          end
          adc_done    = 1'b1;
          adc_data_in = 16'h3081;
          tc_tempc    = tempc_base + 32'(2 * idx);
          idx++;
        end
      end
      if (adc_start === 1'b1 && adc_en) pend = 3;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (adc_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (temp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic new_stream(input int unsigned base);
    seed_gen++;
    tempc_base = base;
  endtask

  task automatic handshake_and_stop();
    temp_ready = 1'b1;
    step();
    temp_ready = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_base = '0; cfg_ref = '0;
    temp_ready = 1'b0; err_clr = 1'b0;
    step(); step();
    checks++;
    if (adc_start !== 1'b0 || busy !== 1'b0 || temp_valid !== 1'b0 || temp_out !== 32'd0 ||
        tc_adc !== 16'd0 || err_timeout !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b busy=%b valid=%b out=%0d adc=%h to=%b ovr=%b required all zero",
               adc_start, busy, temp_valid, temp_out, tc_adc, err_timeout, overrun);
    end
    checks++;
    if (tc_base !== 32'd1 || tc_ref !== 8'd24) begin
      errors++;
      $display("FAIL reset_cfg: base=%0d ref=%0d required 1/24", tc_base, tc_ref);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_normal_average();
    bit seen;
    int prev;
    int starts0;
    new_stream(100);
    adc_en = 1'b1; enable = 1'b1;
    starts0 = n_starts;
    wait_start(40, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL normal_first_start: no adc_start, required one"); end
    prev = cyc;
    for (int k = 1; k < 4; k++) begin
      wait_start(20, seen);
      checks++;
      if (!seen || (cyc - prev) != 16) begin
        errors++;
        $display("FAIL normal_interval%0d: seen=%b gap=%0d required 16", k, seen, cyc - prev);
      end
      prev = cyc;
    end
    wait_valid(20, seen);
    checks++;
    if (!seen || temp_out !== 32'd103) begin
      errors++;
      $display("FAIL normal_avg: valid=%b temp_out=%0d required 103", seen, temp_out);
    end
    checks++;
    if (tc_adc !== 16'h3081) begin
      errors++;
      $display("FAIL normal_tc_adc: %h required 3081", tc_adc);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (temp_valid !== 1'b1 || temp_out !== 32'd103 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL normal_hold: valid=%b out=%0d ovr=%b required 1/103/0", temp_valid, temp_out, overrun);
    end
    checks++;
    if (n_starts - starts0 != 4) begin
      errors++;
      $display("FAIL normal_start_count: %0d required 4", n_starts - starts0);
    end
    temp_ready = 1'b1;
    step();
    temp_ready = 1'b0;
    checks++;
    if (temp_valid !== 1'b0) begin
      errors++;
      $display("FAIL normal_valid_drop: %b required 0", temp_valid);
    end
    enable = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL normal_idle_busy: %b required 0", busy); end
  endtask

  task automatic test_timeout();
    bit seen;
    int t0;
    new_stream(100);
    adc_en = 1'b0; enable = 1'b1;
    wait_start(40, seen);
    t0 = cyc;
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout_start: no adc_start, required one"); end
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: %b required 0", err_timeout); end
    step();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set: to=%b busy=%b required 1/1", err_timeout, busy);
    end
    adc_en = 1'b1;
    wait_start(20, seen);
    checks++;
    if (!seen || (cyc - t0) != 16) begin
      errors++;
      $display("FAIL timeout_next_start: seen=%b gap=%0d required 16", seen, cyc - t0);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: %b required 0", err_timeout); end
    wait_valid(80, seen);
    checks++;
    if (!seen || temp_out !== 32'd103) begin
      errors++;
      $display("FAIL timeout_avg: valid=%b temp_out=%0d required 103", seen, temp_out);
    end
    handshake_and_stop();
  endtask

  task automatic test_backpressure();
    bit seen;
    int bad_start;
    int unstable;
    new_stream(100);
    adc_en = 1'b1; enable = 1'b1;
    wait_valid(100, seen);
    checks++;
    if (!seen || temp_out !== 32'd103) begin
      errors++;
      $display("FAIL bp_avg: valid=%b temp_out=%0d required 103", seen, temp_out);
    end
    bad_start = 0; unstable = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (adc_start !== 1'b0) bad_start++;
      if (temp_out !== 32'd103 || temp_valid !== 1'b1) unstable++;
    end
    checks++;
    if (bad_start != 0 || unstable != 0) begin
      errors++;
      $display("FAIL bp_stall: starts=%0d unstable=%0d required 0/0", bad_start, unstable);
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: %b required 1", overrun); end
    temp_ready = 1'b1;
    step();
    temp_ready = 1'b0;
    checks++;
    if (temp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: %b required 0", temp_valid); end
    wait_start(20, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_resume: no adc_start, required one"); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun_clear: %b required 0", overrun); end
    enable = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_config_and_reset();
    bit seen;
    int stray;
    new_stream(100);
    adc_en = 1'b1; enable = 1'b1;
    wait_start(40, seen);
    checks++;
    if (!seen || tc_base !== 32'd1 || tc_ref !== 8'd24) begin
      errors++;
      $display("FAIL cfg_default: seen=%b base=%0d ref=%0d required 1/24", seen, tc_base, tc_ref);
    end
    step();
    cfg_load = 1'b1; cfg_base = 32'd5; cfg_ref = 8'd12;
    step();
    cfg_load = 1'b0;
    step();
    checks++;
    if (tc_base !== 32'd1 || tc_ref !== 8'd24) begin
      errors++;
      $display("FAIL cfg_hold: base=%0d ref=%0d required 1/24", tc_base, tc_ref);
    end
    wait_start(20, seen);
    checks++;
    if (!seen || tc_base !== 32'd5 || tc_ref !== 8'd12) begin
      errors++;
      $display("FAIL cfg_apply: seen=%b base=%0d ref=%0d required 5/12", seen, tc_base, tc_ref);
    end
    step();
    #3 rst = 1'b1;
    #1;
    checks++;
    if (adc_start !== 1'b0 || busy !== 1'b0 || temp_valid !== 1'b0 || temp_out !== 32'd0 ||
        tc_adc !== 16'd0 || tc_base !== 32'd1 || tc_ref !== 8'd24 ||
        err_timeout !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: start=%b busy=%b valid=%b out=%0d adc=%h base=%0d ref=%0d to=%b ovr=%b required 0/0/0/0/0/1/24/0/0",
               adc_start, busy, temp_valid, temp_out, tc_adc, tc_base, tc_ref, err_timeout, overrun);
    end
    step();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (adc_start !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0 || tc_adc !== 16'd0) begin
      errors++;
      $display("FAIL reset_abort: stray_starts=%0d tc_adc=%h required 0/0000", stray, tc_adc);
    end
    wait_start(10, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_restart: no adc_start, required one"); end
    enable = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_abort();
    bit seen;
    int starts0;
    new_stream(500);
    adc_en = 1'b1; enable = 1'b1;
    for (int k = 0; k < 3; k++) wait_start(40, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_third_start: no adc_start, required one"); end
    for (int i = 0; i < 4; i++) step();
    enable = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || adc_start !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b start=%b required 0/0", busy, adc_start);
    end
    for (int i = 0; i < 6; i++) step();
    new_stream(100);
    starts0 = n_starts;
    enable = 1'b1;
    wait_valid(120, seen);
    checks++;
    if (!seen || temp_out !== 32'd103 || (n_starts - starts0) != 4) begin
      errors++;
      $display("FAIL abort_fresh_avg: valid=%b temp_out=%0d starts=%0d required 103 after 4",
               seen, temp_out, n_starts - starts0);
    end
    handshake_and_stop();
  endtask

  initial begin
    test_reset();
    test_normal_average();
    test_timeout();
    test_backpressure();
    test_config_and_reset();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_sample_controller.md
TEMP_SAMPLE_CONTROLLER -- requirements
Module: temp_sample_controller

Interface
REQ-001 Parameters SHALL be: SAMPLE_DIV (default 16), the sample period in clocks; AVG_LOG2 (default 2), the log2 of the number of samples averaged; CALC_LAT (default 1), the calculator settle clocks; ADC_TIMEOUT (default 8), the clocks to wait for adc_done; DEF_BASE (default 32'd1), the reset tc_base; DEF_REF (default 8'd24), the reset tc_ref.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  run sampling
- cfg_load  in  1  capture cfg_base/cfg_ref into shadow
- cfg_base  in  32  new base
- cfg_ref  in  8  new reference
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  conversion complete
- adc_data_in  in  16  conversion result
- tc_base  out  32  to calculator
- tc_ref  out  8  to calculator
- tc_adc  out  16  to calculator
- tc_tempc  in  32  calculator result
- temp_out  out  32  averaged temperature
- temp_valid  out  1  temp_out valid
- temp_ready  in  1  consumer accepts
- err_timeout  out  1  sticky ADC timeout
- overrun  out  1  sticky missed sample tick
- err_clr  in  1  clear sticky flags
- busy  out  1  state not IDLE

Function
REQ-004 The FSM SHALL have states IDLE, WAIT_TICK, START, CONVERT, CALC, ACCUM and PUBLISH.
REQ-005 The tick counter SHALL reset to 0 on entry from IDLE, SHALL free-run modulo SAMPLE_DIV while enable=1, and tick SHALL mean counter==SAMPLE_DIV-1.
REQ-006 IDLE SHALL go to WAIT_TICK when enable=1.
REQ-007 WAIT_TICK SHALL go to START on tick.
REQ-008 In START, adc_start SHALL be 1 for exactly one cycle, tc_base/tc_ref SHALL load from shadow, the timeout counter SHALL clear, and the FSM SHALL go to CONVERT.
REQ-009 In CONVERT, adc_done=1 SHALL latch adc_data_in into tc_adc and go to CALC.
REQ-010 In CONVERT, after ADC_TIMEOUT cycles without adc_done, the block SHALL set err_timeout, discard the sample (accumulator and sample count untouched), and go to WAIT_TICK.
REQ-011 CALC SHALL wait CALC_LAT cycles and then go to ACCUM.
REQ-012 ACCUM SHALL perform acc += tc_tempc, with acc 32+AVG_LOG2 bits unsigned and no overflow possible.
REQ-013 ACCUM SHALL increment the sample count; when count reaches 2^AVG_LOG2 it SHALL load temp_out = (acc+tc_tempc)>>AVG_LOG2 (truncating), clear acc and count, and go to PUBLISH; otherwise it SHALL go to WAIT_TICK.
REQ-014 In PUBLISH, temp_valid SHALL be 1 and temp_out SHALL be held stable; when temp_valid&temp_ready, the FSM SHALL go to WAIT_TICK (or IDLE if enable=0) and temp_valid SHALL drop the next cycle.
REQ-015 A tick in any state other than WAIT_TICK/IDLE SHALL set overrun; that sample SHALL be skipped, not queued.
REQ-016 enable=0 in WAIT_TICK/START/CONVERT/CALC/ACCUM SHALL go to IDLE at the next edge, clear acc and count, and force adc_start=0; PUBLISH SHALL remain until the handshake completes.
REQ-017 cfg_load SHALL update the shadow registers in any state; tc_base/tc_ref SHALL change only in START.
REQ-018 adc_done outside CONVERT SHALL be ignored.
REQ-019 err_clr SHALL clear err_timeout/overrun; a simultaneous set and clear SHALL leave the flag set.
REQ-020 busy SHALL be 1 whenever the state is not IDLE.

Reset
REQ-021 rst SHALL asynchronously force: IDLE, counters=0, acc=0, adc_start=0, temp_valid=0, temp_out=0, tc_adc=0, tc_base=shadow=DEF_BASE, tc_ref=shadow=DEF_REF, err_timeout=0, overrun=0.
REQ-022 rst mid-operation SHALL abort any conversion or publish with no further adc_start until a new tick.

Verification (defaults)
REQ-023 Reset check: assert rst at an arbitrary time -> all outputs at REQ-021 values in the same cycle, tc_base=1 and tc_ref=24.
REQ-024 Normal averaging: enable=1; ADC model returns 16'h3081 3 cycles after each adc_start; calculator stub returns 100, 102, 104, 106 -> exactly 4 adc_start pulses 16 clocks apart, temp_out=103, temp_valid held until temp_ready.
REQ-025 Timeout: adc_done never asserted -> err_timeout=1 8 cycles after adc_start, acc unchanged; the next tick issues a new adc_start; err_clr -> err_timeout=0.
REQ-026 Backpressure: temp_ready=0 for 40 cycles in PUBLISH -> overrun=1, temp_out stable, no adc_start until the handshake.
REQ-027 Config timing: cfg_load with base=32'd5 and ref=8'd12 during CONVERT -> tc_base/tc_ref unchanged until the next START, then 5/12.
REQ-028 Abort: enable=0 during CALC -> IDLE next cycle, busy=0; re-enabling starts a fresh 4-sample average with no stale data.
